// File: rtl/ram_parity_responder_pkg.sv
// Shared types, constants and parity helper for the parity RAM responder.
// Package name ram_types is what the rest of the RAM slice imports.
package ram_types;

    typedef logic [7:0]  ram_data_in_t;
    typedef logic [15:0] ram_address_t;
    typedef logic [8:0]  ram_data_out_t;

    localparam ram_data_in_t RAM_DATAIN_ALLBITS  = '1;
    localparam ram_address_t RAM_ADDRESS_ALLBITS = '1;

    typedef enum logic {
        CLEAR,
        IDLE
    } ram_resp_state_t;

    function automatic logic ram_parity(ram_data_in_t d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_parity_responder_if.sv
// Request/response bundle between the RAM initiator and the responder.
// inject_err exists only when RAM_PARITY_INJECT_EN is defined.
interface ram_parity_responder_if #(
    parameter int ADDR_W = 16
);
    import ram_types::*;

    logic              write;
    logic              read;
    ram_data_in_t      data_in;
    logic [ADDR_W-1:0] address;
    ram_data_out_t     data_out;
    logic              data_valid;
    logic              busy;
    logic              req_dropped;
`ifdef RAM_PARITY_INJECT_EN
    logic              inject_err;
`endif

    modport master (
`ifdef RAM_PARITY_INJECT_EN
        output inject_err,
`endif
        output write, read, data_in, address,
        input  data_out, data_valid, busy, req_dropped
    );

    modport slave (
`ifdef RAM_PARITY_INJECT_EN
        input  inject_err,
`endif
        input  write, read, data_in, address,
        output data_out, data_valid, busy, req_dropped
    );

endinterface

// File: rtl/ram_parity_responder_clear_sequencer.sv
// Post-reset clear walker: one array write per cycle over the whole depth.
// busy is high exactly while the walk is in progress.
module ram_clear_sequencer
    import ram_types::*;
#(
    parameter int           ADDR_W    = 16,
    parameter ram_data_in_t CLEAR_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output ram_data_out_t     clr_data
);

    localparam ram_data_in_t CLR_BYTE = CLEAR_VAL & RAM_DATAIN_ALLBITS;
    localparam logic [ADDR_W:0] LAST =
        {1'b0, RAM_ADDRESS_ALLBITS[ADDR_W-1:0]};

    ram_resp_state_t state;
    logic [ADDR_W:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    // Terminate on the last word; the counter never wraps
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt[ADDR_W-1:0];
    assign clr_data = {ram_parity(CLR_BYTE), CLR_BYTE};

endmodule

// File: rtl/ram_parity_responder.sv
// Synthesizable parity RAM target: stores {^d, d}, 1-cycle registered reads.
// Define RAM_PARITY_INJECT_EN to add inject_err for bad-parity writes.
module ram_parity_responder
    import ram_types::*;
#(
    parameter int           ADDR_W    = 16,
    parameter ram_data_in_t CLEAR_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    ram_parity_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    ram_data_out_t     mem [DEPTH];
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    ram_data_out_t     clr_data;
    logic              req;
    logic              ext_wr;
    logic              ext_rd;
    logic              wr_par;
    logic              we;
    logic [ADDR_W-1:0] wa;
    ram_data_out_t     wd;

    ram_clear_sequencer #(
        .ADDR_W   (ADDR_W),
        .CLEAR_VAL(CLEAR_VAL)
    ) u_clr (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr),
        .clr_data(clr_data)
    );

    assign req    = bus.write | bus.read;
    assign ext_wr = bus.write & ~busy;
    assign ext_rd = bus.read & ~bus.write & ~busy;

`ifdef RAM_PARITY_INJECT_EN
    assign wr_par = ram_parity(bus.data_in) ^ bus.inject_err;
`else
    assign wr_par = ram_parity(bus.data_in);
`endif

    // Clear and external writes never overlap: ext_wr needs ~busy
    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        unique case (1'b1)
            clr_we: begin
                we = 1'b1;
                wa = clr_addr;
                wd = clr_data;
            end
            ext_wr: begin
                we = 1'b1;
                wa = bus.address;
                wd = {wr_par, bus.data_in};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_out    <= '0;
            bus.data_valid  <= 1'b0;
            bus.req_dropped <= 1'b0;
        end else begin
            bus.data_valid  <= ext_rd;
            bus.req_dropped <= req & busy;
            if (ext_rd) begin
                bus.data_out <= mem[bus.address];
            end
        end
    end

    assign bus.busy = busy;

endmodule

// File: tb/tb_ram_parity_responder.sv
// Directed bench: small (ADDR_W=4) and full (ADDR_W=16) responder instances.
// Inject checks run only when RAM_PARITY_INJECT_EN is defined.
module tb_ram_parity_responder;

    logic clk = 1'b0;
    logic reset_s;
    logic reset_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_parity_responder_if #(.ADDR_W(4))  ifs ();
    ram_parity_responder_if #(.ADDR_W(16)) ifb ();

    ram_parity_responder #(.ADDR_W(4)) u_s (
        .clk  (clk),
        .reset(reset_s),
        .bus  (ifs)
    );

    ram_parity_responder #(.ADDR_W(16)) u_b (
        .clk  (clk),
        .reset(reset_b),
        .bus  (ifb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] r_addr [6];
    logic [7:0] r_data [6];
    logic [8:0] r_exp  [6];

    initial begin
        r_addr = '{4'h2, 4'h6, 4'h9, 4'hB, 4'hC, 4'hF};
        r_data = '{8'h3C, 8'h01, 8'hFE, 8'h55, 8'h80, 8'hE3};
        r_exp  = '{9'h03C, 9'h101, 9'h1FE, 9'h055, 9'h180, 9'h1E3};

        reset_s = 1'b1;
        reset_b = 1'b1;
        ifs.write = 1'b0; ifs.read = 1'b0;
        ifs.data_in = '0; ifs.address = '0;
        ifb.write = 1'b0; ifb.read = 1'b0;
        ifb.data_in = '0; ifb.address = '0;
`ifdef RAM_PARITY_INJECT_EN
        ifs.inject_err = 1'b0;
        ifb.inject_err = 1'b0;
`endif
        step();
        step();
        chk("rst_busy", ifs.busy, 1);
        chk("rst_dout", ifs.data_out, 0);
        chk("rst_valid", ifs.data_valid, 0);
        chk("rst_drop", ifs.req_dropped, 0);

        reset_s = 1'b0;
        reset_b = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                ifs.write = 1'b1;
                ifs.address = 4'h0;
                ifs.data_in = 8'hFF;
            end
            step();
            ifs.write = 1'b0;
            if (k == 3) chk("drop_pulse", ifs.req_dropped, 1);
            if (k == 4) chk("drop_end", ifs.req_dropped, 0);
            chk($sformatf("busy_clr%0d", k), ifs.busy, (k < 16) ? 1 : 0);
        end

        for (int a = 0; a < 16; a++) begin
            ifs.read = 1'b1;
            ifs.address = 4'(a);
            step();
            chk($sformatf("clr_rd%0d", a), ifs.data_out, 0);
            chk("clr_valid", ifs.data_valid, 1);
        end
        ifs.read = 1'b0;
        step();
        chk("idle_valid", ifs.data_valid, 0);

        ifs.write = 1'b1; ifs.address = 4'h1; ifs.data_in = 8'h07;
        step();
        chk("wr_novalid", ifs.data_valid, 0);
        ifs.write = 1'b0; ifs.read = 1'b1;
        step();
        ifs.read = 1'b0;
        chk("raw_07", ifs.data_out, 9'h107);
        chk("raw_valid", ifs.data_valid, 1);
        step();
        chk("hold_dout", ifs.data_out, 9'h107);
        chk("hold_valid", ifs.data_valid, 0);

        for (int i = 0; i < 6; i++) begin
            ifs.write = 1'b1;
            ifs.address = r_addr[i];
            ifs.data_in = r_data[i];
            step();
        end
        ifs.write = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            ifs.read = 1'b1;
            ifs.address = r_addr[i];
            step();
            chk($sformatf("rev_rd%0d", i), ifs.data_out, r_exp[i]);
            chk("rev_valid", ifs.data_valid, 1);
        end
        ifs.read = 1'b0;

        reset_s = 1'b1;
        #1;
        chk("rst2_dout", ifs.data_out, 0);
        chk("rst2_valid", ifs.data_valid, 0);
        step();
        reset_s = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        chk("mid_busy", ifs.busy, 1);
        ifs.read = 1'b1;
        ifs.address = 4'h1;
        reset_s = 1'b1;
        #1;
        chk("mid_rst_busy", ifs.busy, 1);
        step();
        chk("mid_rst_dout", ifs.data_out, 0);
        chk("mid_rst_valid", ifs.data_valid, 0);
        ifs.read = 1'b0;
        reset_s = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("rerun_busy%0d", k), ifs.busy, (k < 16) ? 1 : 0);
        end
        ifs.read = 1'b1;
        ifs.address = 4'h1;
        step();
        ifs.read = 1'b0;
        chk("rerun_rd1", ifs.data_out, 0);
        chk("rerun_valid", ifs.data_valid, 1);

        for (int n = 0; n < 70000; n++) begin
            if (!ifb.busy) break;
            step();
        end
        chk("big_clear_done", ifb.busy, 0);

        ifb.write = 1'b1; ifb.address = 16'h1234; ifb.data_in = 8'hA5;
        step();
        ifb.write = 1'b0; ifb.read = 1'b1;
        step();
        ifb.read = 1'b0;
        chk("rd_1234", ifb.data_out, 9'h0A5);
        chk("rd_1234_valid", ifb.data_valid, 1);
        step();
        chk("rd_1234_pulse", ifb.data_valid, 0);

        ifb.write = 1'b1; ifb.address = 16'h0001; ifb.data_in = 8'h07;
        step();
        ifb.write = 1'b0; ifb.read = 1'b1;
        step();
        ifb.read = 1'b0;
        chk("rd_0001", ifb.data_out, 9'h107);

        ifb.write = 1'b1; ifb.read = 1'b1;
        ifb.address = 16'h0010; ifb.data_in = 8'h3C;
        step();
        ifb.write = 1'b0; ifb.read = 1'b0;
        chk("wr_rd_valid", ifb.data_valid, 0);
        chk("wr_rd_drop", ifb.req_dropped, 0);
        chk("wr_rd_dout", ifb.data_out, 9'h107);
        ifb.read = 1'b1;
        step();
        ifb.read = 1'b0;
        chk("rd_0010", ifb.data_out, 9'h03C);

`ifdef RAM_PARITY_INJECT_EN
        ifb.write = 1'b1; ifb.inject_err = 1'b1;
        ifb.address = 16'h0020; ifb.data_in = 8'hA5;
        step();
        ifb.write = 1'b0; ifb.inject_err = 1'b0; ifb.read = 1'b1;
        step();
        ifb.read = 1'b0;
        chk("inj_bad", ifb.data_out, 9'h1A5);
        ifb.write = 1'b1;
        step();
        ifb.write = 1'b0; ifb.read = 1'b1; ifb.inject_err = 1'b1;
        step();
        ifb.read = 1'b0; ifb.inject_err = 1'b0;
        chk("inj_good", ifb.data_out, 9'h0A5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_parity_responder.md
Name: ram_parity_responder

Overview:
- Responder (memory) end of the 8-bit parity RAM interface. The existing bench drives this interface as initiator; this block is the target it talks to.
- Stores 8-bit bytes with a generated even-parity bit and returns a 9-bit word {parity, data} on reads, with 1-cycle registered latency.
- Clears its whole array after reset using an internal sequencer. Replaces the behavioural memory model in integration and gives the checker side a synthesizable target.

Parameters:
- ADDR_W, 16, address width; DEPTH = 2**ADDR_W words.
- CLEAR_VAL, 8'h00, byte written to every location during post-reset clear.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- write  input  1  write strobe, sampled at rising clk
- read  input  1  read strobe, sampled at rising clk
- data_in  input  8  write data
- address  input  ADDR_W  word address
- data_out  output  9  {parity, data}; bit 8 = ^data[7:0]
- data_valid  output  1  one-cycle pulse: data_out holds new read data
- busy  output  1  clear sequence in progress; requests ignored
- req_dropped  output  1  one-cycle pulse: read or write arrived while busy

Behaviour:
- Reset (async assert, sync release):
  - data_out = 9'h000, data_valid = 0, req_dropped = 0, busy = 1.
  - Clear address counter = 0; FSM = CLEAR.
  - The array itself is not reset asynchronously.
- FSM states:
  - CLEAR: each cycle writes {^CLEAR_VAL, CLEAR_VAL} to the counter address and increments the counter. After writing address DEPTH-1, go to IDLE. busy falls on the first IDLE cycle, i.e. DEPTH cycles after reset release.
  - IDLE: serve requests. No return to CLEAR except through reset.
- Reset asserted mid-clear: counter restarts at 0 and the full clear reruns.
- Write (IDLE, write=1):
  - At the edge, mem[address] <= {^data_in, data_in}.
  - data_out and data_valid are unaffected.
- Read (IDLE, read=1, write=0):
  - At the edge, data_out <= mem[address] and data_valid <= 1 for exactly one cycle.
  - Back-to-back reads give one valid pulse per request.
- Write and read both high: write wins, read is ignored, data_valid = 0, no drop pulse.
- Read of an address written on the immediately preceding edge returns the new data (array update precedes the read).
- No read: data_out holds its last value and data_valid = 0.
- Any request while busy: no array access, req_dropped = 1 for one cycle.
- Address wrap: the clear counter is ADDR_W+1 bits and terminates on DEPTH-1; no wrap to 0.
- Parity is always recomputed on write; the stored parity bit is never taken from the port.

Optional Feature:
- Macro RAM_PARITY_INJECT_EN.
- Defined:
  - Adds input port inject_err (1 bit).
  - A write with inject_err=1 stores {~(^data_in), data_in}, so a bad parity bit reads back.
  - inject_err is ignored during CLEAR and on reads.
- Undefined: the port is absent and parity is always correct.

Decomposition:
- Shared package ram_types holds:
  - ram_data_in_t (8b), ram_address_t (16b), ram_data_out_t (9b);
  - constants RAM_DATAIN_ALLBITS and RAM_ADDRESS_ALLBITS;
  - a new function ram_parity(ram_data_in_t) returning a 1-bit XOR reduction;
  - an FSM state enum ram_resp_state_t {CLEAR, IDLE}.
- Sub-module ram_clear_sequencer owns the clear counter, the busy flag and the clear write port. The top-level block muxes its write port against the external request path.

Test Plan:
- ADDR_W=4, reset pulse then release: busy high for 16 cycles then low; every address reads 9'h000; write at cycle 3 of the clear gives a req_dropped pulse and no array change.
- Write 8'hA5 to 0x1234, then read 0x1234: data_out=9'h0A5 with data_valid one cycle after the read edge. Write 8'h07 to 0x0001, read back: 9'h107.
- Six random write/address pairs, then reads in reverse order: every read matches {^d, d}; zero errors.
- read=write=1 at 0x0010 with data 8'h3C: data_valid stays 0; a later read returns 9'h03C.
- Reset asserted at clear cycle 8 (ADDR_W=4), released: busy stays high a further full 16 cycles; data_out=0 and data_valid=0 during reset.
- RAM_PARITY_INJECT_EN defined: write 8'hA5 with inject_err=1, read back 9'h1A5; a subsequent normal write of 8'hA5 reads back 9'h0A5.
